// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: frame-parser states and
// the protocol byte values.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddrH,
    StAddrL,
    StLen,
    StData,
    StCsum,
    StResp
  } loader_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'h5A;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_RUN   = 8'h02;
  localparam logic [7:0] ACK_BYTE  = 8'hA5;
  localparam logic [7:0] NAK_BYTE  = 8'hEE;

endpackage

// File: rtl/inst_mem_loader.sv
// Byte-stream boot loader: parses framed WRITE/RUN commands from UART RX, streams payload
// words into instruction memory, controls core pause/run and answers ACK/NAK on TX.
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter int unsigned PC_BITWIDTH    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   inst_mem_we,
  output logic [PC_BITWIDTH-3:0] inst_mem_wr_addr,
  output logic [31:0]            inst_mem_data_in,
  output logic                   pause,
  output logic                   run_pulse,
  output logic                   busy
);

  localparam int unsigned AW   = PC_BITWIDTH - 2;
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  loader_state_e   state_q, state_d;
  logic            is_write_q, is_write_d;
  logic            is_run_q, is_run_d;
  logic            nak_q, nak_d;
  logic [7:0]      csum_q, csum_d;
  logic [7:0]      addr_h_q, addr_h_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [8:0]      words_left_q, words_left_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [23:0]     word_q, word_d;
  logic [CntW-1:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            we_q, we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]     mem_data_q, mem_data_d;
  logic            pause_q, pause_d;
  logic            run_pulse_q, run_pulse_d;

  logic [7:0]  csum_sum;
  logic        frame_ok;
  logic [13:0] word_addr_full;

  // ADDR bits [1:0] are a byte offset and are dropped.
  assign word_addr_full = {addr_h_q, rx_data[7:2]};
  assign csum_sum       = csum_q + rx_data;
  assign frame_ok       = (csum_sum == 8'h00) && !nak_q;

  always_comb begin
    state_d      = state_q;
    is_write_d   = is_write_q;
    is_run_d     = is_run_q;
    nak_d        = nak_q;
    csum_d       = csum_q;
    addr_h_d     = addr_h_q;
    wr_addr_d    = wr_addr_q;
    words_left_d = words_left_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    idle_cnt_d   = idle_cnt_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    we_d         = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    pause_d      = pause_q;
    run_pulse_d  = 1'b0;

    // Inter-byte timeout while a frame is being parsed; abandons silently.
    if (state_q != StIdle && state_q != StResp) begin
      if (rx_valid) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q == CntLast) begin
        idle_cnt_d = '0;
        state_d    = StIdle;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d    = StCmd;
          csum_d     = '0;
          nak_d      = 1'b0;
          is_write_d = 1'b0;
          is_run_d   = 1'b0;
          byte_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end
      StCmd: begin
        if (rx_valid) begin
          csum_d     = csum_sum;
          state_d    = StAddrH;
          is_write_d = (rx_data == CMD_WRITE);
          is_run_d   = (rx_data == CMD_RUN);
          if (rx_data != CMD_WRITE && rx_data != CMD_RUN) nak_d = 1'b1;
          if (rx_data == CMD_WRITE) pause_d = 1'b1;
        end
      end
      StAddrH: begin
        if (rx_valid) begin
          csum_d   = csum_sum;
          addr_h_d = rx_data;
          state_d  = StAddrL;
        end
      end
      StAddrL: begin
        if (rx_valid) begin
          csum_d    = csum_sum;
          wr_addr_d = word_addr_full[AW-1:0];
          state_d   = StLen;
        end
      end
      StLen: begin
        if (rx_valid) begin
          csum_d       = csum_sum;
          words_left_d = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          // RUN carries no payload, so a nonzero LEN is a malformed frame.
          if (is_run_q && rx_data != 8'h00) nak_d = 1'b1;
          state_d = (is_write_q && !nak_q) ? StData : StCsum;
        end
      end
      StData: begin
        if (rx_valid) begin
          csum_d     = csum_sum;
          word_d     = {word_q[15:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d         = 1'b1;
            mem_data_d   = {word_q, rx_data};
            mem_addr_d   = wr_addr_q;
            wr_addr_d    = wr_addr_q + 1'b1;
            words_left_d = words_left_q - 9'd1;
            if (words_left_q == 9'd1) state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (rx_valid) begin
          csum_d     = csum_sum;
          state_d    = StResp;
          tx_valid_d = 1'b1;
          tx_data_d  = frame_ok ? ACK_BYTE : NAK_BYTE;
          if (frame_ok && is_run_q) begin
            pause_d     = 1'b0;
            run_pulse_d = 1'b1;
          end
        end
      end
      StResp: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      is_write_q   <= 1'b0;
      is_run_q     <= 1'b0;
      nak_q        <= 1'b0;
      csum_q       <= '0;
      addr_h_q     <= '0;
      wr_addr_q    <= '0;
      words_left_q <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      idle_cnt_q   <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      pause_q      <= 1'b0;
      run_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_write_q   <= is_write_d;
      is_run_q     <= is_run_d;
      nak_q        <= nak_d;
      csum_q       <= csum_d;
      addr_h_q     <= addr_h_d;
      wr_addr_q    <= wr_addr_d;
      words_left_q <= words_left_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      idle_cnt_q   <= idle_cnt_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      pause_q      <= pause_d;
      run_pulse_q  <= run_pulse_d;
    end
  end

  assign tx_data          = tx_data_q;
  assign tx_valid         = tx_valid_q;
  assign inst_mem_we      = we_q;
  assign inst_mem_wr_addr = mem_addr_q;
  assign inst_mem_data_in = mem_data_q;
  assign pause            = pause_q;
  assign run_pulse        = run_pulse_q;
  assign busy             = (state_q != StIdle);

endmodule
